// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared single-port data memory.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make m0 always win simultaneous requests.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m0_wmask,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [DATA_W-1:0] m1_wmask,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req until it sees a one-cycle gnt (fields are
    // sampled in that cycle); completion is a one-cycle rvalid with rdata valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                owner;
    logic                last;
    logic [1:0]          lat_cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   lat_wmask;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                any_req;
    logic                pick_m1;

    assign any_req = m0_req | m1_req;

    // pick_m1 is only meaningful while any_req is high.
    always_comb begin
        pick_m1 = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pick_m1 = m1_req & ~m0_req;
`else
        pick_m1 = m1_req & (~m0_req | ~last);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? RESP : WAIT;
            WAIT:    if (lat_cnt == 2'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_cnt   <= 2'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= pick_m1;
                        last      <= pick_m1;
                        lat_we    <= pick_m1 ? m1_we    : m0_we;
                        lat_addr  <= pick_m1 ? m1_addr  : m0_addr;
                        lat_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                        lat_wmask <= pick_m1 ? m1_wmask : m0_wmask;
                    end
                end
                ISSUE: begin
                    if (!lat_we) lat_cnt <= LAT_LOAD;
                end
                WAIT: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else if (owner) begin
                        rdata1_q <= mem_rdata;
                    end else begin
                        rdata0_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                m0_gnt = any_req & ~pick_m1;
                m1_gnt = any_req & pick_m1;
            end
            ISSUE: begin
                mem_en = 1'b1;
                mem_we = lat_we;
            end
            RESP: begin
                m0_rvalid = ~owner;
                m1_rvalid = owner;
            end
            default: ;
        endcase
    end

    // Memory data lines follow the latched request, so they hold outside ISSUE.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata & lat_wmask;
    assign mem_wmask = lat_wmask;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) with behavioural
// memories; a completion scoreboard checks every rvalid against queued expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m0_wmask = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0, m1_wmask = '0;
    int          sel = 0;
    int          cyc = 0;

    logic        o_m0_gnt[2], o_m0_rvalid[2], o_m1_gnt[2], o_m1_rvalid[2];
    logic        o_mem_en[2], o_mem_we[2], o_busy[2];
    logic [31:0] o_m0_rdata[2], o_m1_rdata[2], o_mem_addr[2], o_mem_wdata[2], o_mem_wmask[2];
    logic [31:0] mem_rdata[2];
    logic [1:0]  o_state[2];

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] ref_mem[2][256];
    logic [31:0] last_rd[2][2];

    int          checks = 0, errors = 0;
    int          g0_cnt = 0, g1_cnt = 0, en_cnt = 0, rv0_cnt = 0;
    int          en_cyc = -1, rv0_cyc = -1, rv1_cyc = -1;
    logic        iss_we;
    logic [31:0] iss_addr, iss_wdata, iss_wmask;
    logic        m1_act = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int j);
        return 32'h1000_0000 + 32'(j) * 32'h0101;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic        r0, r1;
        logic [31:0] mem[256];
        logic        pv[5];
        logic [7:0]  pa[5];

        assign r0 = m0_req && (sel == gi);
        assign r1 = m1_req && (sel == gi);

        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(r0), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
            .m0_gnt(o_m0_gnt[gi]), .m0_rvalid(o_m0_rvalid[gi]), .m0_rdata(o_m0_rdata[gi]),
            .m1_req(r1), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
            .m1_gnt(o_m1_gnt[gi]), .m1_rvalid(o_m1_rvalid[gi]), .m1_rdata(o_m1_rdata[gi]),
            .mem_en(o_mem_en[gi]), .mem_we(o_mem_we[gi]), .mem_addr(o_mem_addr[gi]),
            .mem_wdata(o_mem_wdata[gi]), .mem_wmask(o_mem_wmask[gi]), .mem_rdata(mem_rdata[gi]),
            .busy(o_busy[gi]), .dbg_state(o_state[gi])
        );

        initial begin
            for (int j = 0; j < 256; j++) mem[j] = pat(j);
            mem[16] = 32'hDEAD_BEEF;
            for (int j = 0; j < 5; j++) begin
                pv[j] = 1'b0;
                pa[j] = '0;
            end
            mem_rdata[gi] = '0;
        end

        // Read data is only valid LAT cycles after the strobe; garbage otherwise.
        always @(negedge clk) begin
            for (int j = 4; j > 0; j--) begin
                pv[j] = pv[j-1];
                pa[j] = pa[j-1];
            end
            pv[0] = o_mem_en[gi] && !o_mem_we[gi];
            pa[0] = o_mem_addr[gi][9:2];
            if (o_mem_en[gi] && o_mem_we[gi])
                mem[o_mem_addr[gi][9:2]] = (mem[o_mem_addr[gi][9:2]] & ~o_mem_wmask[gi]) |
                                           (o_mem_wdata[gi] & o_mem_wmask[gi]);
            mem_rdata[gi] = pv[LAT] ? mem[pa[LAT]] : $urandom;
        end
    end

    // Monitor and scoreboard on the selected instance.
    always @(negedge clk) begin
        logic [31:0] e;
        if (o_m0_gnt[sel]) g0_cnt++;
        if (o_m1_gnt[sel]) g1_cnt++;
        if (o_mem_en[sel]) begin
            en_cnt++;
            en_cyc    = cyc;
            iss_we    = o_mem_we[sel];
            iss_addr  = o_mem_addr[sel];
            iss_wdata = o_mem_wdata[sel];
            iss_wmask = o_mem_wmask[sel];
        end
        if (o_m1_gnt[sel] || o_m1_rvalid[sel] || o_m1_rdata[sel] != 0) m1_act = 1'b1;
        if (o_m0_rvalid[sel]) begin
            rv0_cyc = cyc;
            rv0_cnt++;
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL m0_rvalid_unexpected: got rvalid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = exp0_q.pop_front();
                if (o_m0_rdata[sel] !== e) begin
                    errors++;
                    $display("FAIL m0_rdata: got %h, expected %h", o_m0_rdata[sel], e);
                end
            end
        end
        if (o_m1_rvalid[sel]) begin
            rv1_cyc = cyc;
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL m1_rvalid_unexpected: got rvalid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = exp1_q.pop_front();
                if (o_m1_rdata[sel] !== e) begin
                    errors++;
                    $display("FAIL m1_rdata: got %h, expected %h", o_m1_rdata[sel], e);
                end
            end
        end
    end

    // Reference memory update and expected completion data for a granted access.
    function automatic logic [31:0] exp_of(input int p, input logic we, input logic [31:0] addr,
                                           input logic [31:0] wdata, input logic [31:0] wmask);
        int idx;
        idx = int'(addr[9:2]);
        if (we) begin
            ref_mem[sel][idx] = (ref_mem[sel][idx] & ~wmask) | (wdata & wmask);
            return last_rd[sel][p];
        end
        last_rd[sel][p] = ref_mem[sel][idx];
        return ref_mem[sel][idx];
    endfunction

    task automatic push_exp(input int p, input logic [31:0] e);
        if (p == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
    endtask

    task automatic access(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] wmask,
                          input bit push, output int gcyc);
        @(posedge clk); #1;
        if (p == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask; m1_req = 1'b1;
        end
        gcyc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((p == 0) ? o_m0_gnt[sel] : o_m1_gnt[sel]) begin
                gcyc = cyc;
                break;
            end
        end
        checks++;
        if (gcyc < 0) begin
            errors++;
            $display("FAIL grant_timeout: port %0d got no gnt within 50 cycles", p);
        end else if (push) begin
            push_exp(p, exp_of(p, we, addr, wdata, wmask));
        end
        @(posedge clk); #1;
        // Scramble fields after the grant; the DUT must use its latched copy.
        if (p == 0) begin
            m0_req = 1'b0; m0_addr = $urandom; m0_wdata = $urandom; m0_wmask = $urandom; m0_we = 1'($urandom);
        end else begin
            m1_req = 1'b0; m1_addr = $urandom; m1_wdata = $urandom; m1_wmask = $urandom; m1_we = 1'($urandom);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (exp0_q.size() == 0 && exp1_q.size() == 0 && !o_busy[sel]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL completion_timeout: pending m0=%0d m1=%0d busy=%0b, expected all done",
                     exp0_q.size(), exp1_q.size(), o_busy[sel]);
            exp0_q.delete();
            exp1_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        for (int i = 0; i < 2; i++) for (int p = 0; p < 2; p++) last_rd[i][p] = '0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({o_m0_gnt[i], o_m1_gnt[i], o_m0_rvalid[i], o_m1_rvalid[i], o_mem_en[i], o_mem_we[i], o_busy[i]} !== 7'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got %b, expected 0000000", i,
                         {o_m0_gnt[i], o_m1_gnt[i], o_m0_rvalid[i], o_m1_rvalid[i], o_mem_en[i], o_mem_we[i], o_busy[i]});
            end
            checks++;
            if (o_state[i] !== 2'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %0d, expected 0", i, o_state[i]);
            end
            checks++;
            if ({o_m0_rdata[i], o_m1_rdata[i], o_mem_addr[i], o_mem_wdata[i], o_mem_wmask[i]} !== 160'b0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got %h %h %h %h %h, expected all 0", i,
                         o_m0_rdata[i], o_m1_rdata[i], o_mem_addr[i], o_mem_wdata[i], o_mem_wmask[i]);
            end
        end
    endtask

    task automatic test_read_lat1();
        int g;
        sel = 0;
        m1_act = 1'b0;
        rv0_cyc = -1;
        access(0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, g);
        wait_done();
        checks++;
        if (en_cyc != g + 1) begin
            errors++;
            $display("FAIL rd1_mem_en_cycle: got %0d, expected %0d", en_cyc, g + 1);
        end
        checks++;
        if (rv0_cyc != g + 3) begin
            errors++;
            $display("FAIL rd1_rvalid_cycle: got %0d, expected %0d", rv0_cyc, g + 3);
        end
        checks++;
        if (o_m0_rdata[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd1_rdata_hold: got %h, expected deadbeef", o_m0_rdata[0]);
        end
        checks++;
        if (m1_act !== 1'b0) begin
            errors++;
            $display("FAIL rd1_m1_quiet: got m1 activity=1, expected 0");
        end
    endtask

    task automatic test_write_m1();
        int g;
        sel = 0;
        rv1_cyc = -1;
        access(1, 1'b1, 32'h100, 32'h1234_5678, 32'h0000_FFFF, 1'b1, g);
        wait_done();
        checks++;
        if ({iss_we, iss_addr, iss_wdata, iss_wmask} !== {1'b1, 32'h100, 32'h0000_5678, 32'h0000_FFFF}) begin
            errors++;
            $display("FAIL wr_issue: got we=%b addr=%h wdata=%h wmask=%h, expected we=1 addr=100 wdata=00005678 wmask=0000ffff",
                     iss_we, iss_addr, iss_wdata, iss_wmask);
        end
        checks++;
        if (rv1_cyc != g + 2) begin
            errors++;
            $display("FAIL wr_rvalid_cycle: got %0d, expected %0d", rv1_cyc, g + 2);
        end
        access(0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, g);
        wait_done();
        checks++;
        if (o_m0_rdata[0] !== 32'h1000_5678) begin
            errors++;
            $display("FAIL wr_readback: got %h, expected 10005678", o_m0_rdata[0]);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int ord[4];
        int gc[4];
        int exp_ord[4];
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        do_reset();
        sel = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            ord[i] = -1;
            gc[i] = 0;
        end
        @(posedge clk); #1;
        m0_we = 1'b0; m0_addr = 32'h80; m1_we = 1'b0; m1_addr = 32'hC0;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk);
            if (o_m0_gnt[0]) begin
                ord[n] = 0; gc[n] = cyc; n++;
                push_exp(0, exp_of(0, 1'b0, 32'h80, 32'h0, 32'h0));
            end else if (o_m1_gnt[0]) begin
                ord[n] = 1; gc[n] = cyc; n++;
                push_exp(1, exp_of(1, 1'b0, 32'hC0, 32'h0, 32'h0));
            end
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        wait_done();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ord[i] != exp_ord[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got port %0d, expected port %0d", i, ord[i], exp_ord[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gc[i+1] - gc[i] != 4) begin
                errors++;
                $display("FAIL rr_spacing[%0d]: got %0d cycles, expected 4", i, gc[i+1] - gc[i]);
            end
        end
    endtask

    task automatic test_lat3_read();
        int g;
        do_reset();
        sel = 1;
        rv0_cyc = -1;
        access(0, 1'b0, 32'h44, 32'h0, 32'h0, 1'b1, g);
        wait_done();
        checks++;
        if (rv0_cyc != g + 5) begin
            errors++;
            $display("FAIL rd3_rvalid_cycle: got %0d, expected %0d", rv0_cyc, g + 5);
        end
        checks++;
        if (o_m0_rdata[1] !== 32'h1000_1111) begin
            errors++;
            $display("FAIL rd3_rdata: got %h, expected 10001111", o_m0_rdata[1]);
        end
        sel = 0;
    endtask

    task automatic test_reset_abort();
        int g;
        int rv_b;
        int win;
        sel = 0;
        access(0, 1'b0, 32'h48, 32'h0, 32'h0, 1'b0, g);
        rv_b = rv0_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        for (int p = 0; p < 2; p++) last_rd[0][p] = '0;
        @(negedge clk);
        checks++;
        if (o_busy[0] !== 1'b0 || o_state[0] !== 2'd0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b state=%0d, expected busy=0 state=0", o_busy[0], o_state[0]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rv0_cnt != rv_b) begin
            errors++;
            $display("FAIL abort_no_rvalid: got %0d rvalid pulses, expected 0", rv0_cnt - rv_b);
        end
        checks++;
        if (o_m0_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL abort_rdata: got %h, expected 0", o_m0_rdata[0]);
        end
        win = -1;
        @(posedge clk); #1;
        m0_we = 1'b0; m0_addr = 32'h4C; m1_we = 1'b0; m1_addr = 32'h50;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_m0_gnt[0]) begin
                win = 0;
                push_exp(0, exp_of(0, 1'b0, 32'h4C, 32'h0, 32'h0));
                break;
            end
            if (o_m1_gnt[0]) begin
                win = 1;
                push_exp(1, exp_of(1, 1'b0, 32'h50, 32'h0, 32'h0));
                break;
            end
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        wait_done();
        checks++;
        if (win != 0) begin
            errors++;
            $display("FAIL abort_tie_winner: got port %0d, expected port 0", win);
        end
    endtask

    task automatic test_busy_req();
        int g;
        int g1c;
        int en_b;
        int g1_b;
        sel = 0;
        rv0_cyc = -1;
        access(0, 1'b0, 32'h54, 32'h0, 32'h0, 1'b1, g);
        m1_we = 1'b0; m1_addr = 32'h58; m1_req = 1'b1;
        g1c = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_m1_gnt[0]) begin
                g1c = cyc;
                push_exp(1, exp_of(1, 1'b0, 32'h58, 32'h0, 32'h0));
                break;
            end
        end
        @(posedge clk); #1;
        m1_req = 1'b0;
        wait_done();
        checks++;
        if (rv0_cyc != g + 3 || g1c != rv0_cyc + 1) begin
            errors++;
            $display("FAIL busy_grant_cycle: got m0 rvalid %0d m1 gnt %0d, expected %0d and %0d",
                     rv0_cyc, g1c, g + 3, g + 4);
        end
        access(0, 1'b0, 32'h5C, 32'h0, 32'h0, 1'b1, g);
        m1_we = 1'b0; m1_addr = 32'h60; m1_req = 1'b1;
        @(posedge clk); #1;
        m1_req = 1'b0;
        en_b = en_cnt;
        g1_b = g1_cnt;
        wait_done();
        repeat (4) @(negedge clk);
        checks++;
        if (en_cnt != en_b || g1_cnt != g1_b) begin
            errors++;
            $display("FAIL dropped_req: got %0d mem_en and %0d m1 gnt, expected 0 and 0",
                     en_cnt - en_b, g1_cnt - g1_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) ref_mem[i][j] = pat(j);
            ref_mem[i][16] = 32'hDEAD_BEEF;
        end
        test_reset();
        test_read_lat1();
        test_write_m1();
        test_round_robin();
        test_lat3_read();
        test_reset_abort();
        test_busy_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
